// File: rtl/gain_shift_apply_pkg.sv
// gain_shift_apply_pkg: shared rx constants, shift-FSM encoding and saturation width helper.
package gain_shift_apply_pkg;
    typedef enum logic [1:0] {IDLE, STEP_WAIT, FROZEN} state_t;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int MAX_SHIFT_DEF = 4;
    function automatic int sat_width(input int dw, input int ms);
        return dw + ms;
    endfunction
    localparam int SAT_WIDTH = sat_width(DATA_WIDTH_DEF, MAX_SHIFT_DEF);
endpackage

// File: rtl/gain_shift_apply_if.sv
// gain_shift_apply_if: I/Q sample stream in and shifted/saturated stream out.
interface gain_shift_apply_if #(parameter int DATA_WIDTH = 16);
    logic in_valid;
    logic signed [DATA_WIDTH-1:0] i_in, q_in;
    logic out_valid, sat_pulse;
    logic signed [DATA_WIDTH-1:0] i_out, q_out;
    modport master (output in_valid, i_in, q_in, input out_valid, i_out, q_out, sat_pulse);
    modport slave (input in_valid, i_in, q_in, output out_valid, i_out, q_out, sat_pulse);
endinterface

// File: rtl/gain_shift_apply_sat_shift.sv
// sat_shift: combinational left shift in a guard-extended word, then saturate back to DW bits.
module sat_shift import gain_shift_apply_pkg::*; #(
    parameter int DW = DATA_WIDTH_DEF,
    parameter int MS = MAX_SHIFT_DEF
) (
    input  logic signed [DW-1:0] d,
    input  logic [2:0]           sh,
    output logic signed [DW-1:0] y,
    output logic                 sat
);
    localparam int W = sat_width(DW, MS);
    logic signed [W-1:0] w;
    always_comb begin
        w = {{MS{d[DW-1]}}, d} << sh;
        // fits only when every bit above the result's sign bit copies it
        sat = !((&w[W-1:DW-1]) || !(|w[W-1:DW-1]));
        y = sat ? {w[W-1], {(DW-1){!w[W-1]}}} : w[DW-1:0];
    end
endmodule

// File: rtl/gain_shift_apply.sv
// gain_shift_apply: rate-limited shift FSM plus 2-stage I/Q shift-and-saturate pipeline.
module gain_shift_apply import gain_shift_apply_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_SHIFT = MAX_SHIFT_DEF,
    parameter int STEP_INTERVAL = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           num_shift_req,
    input  logic                 pkt_active,
    gain_shift_apply_if.slave    s,
    output logic [2:0]           cur_shift,
    output logic                 shift_changed
);
    localparam int CW = $clog2(STEP_INTERVAL + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] req_c, shift_n, s1;
    logic step, v1, i_sat, q_sat;
    logic signed [DATA_WIDTH-1:0] i1, q1, i_y, q_y;
    always_comb begin
        req_c = num_shift_req > 3'(MAX_SHIFT) ? 3'(MAX_SHIFT) : num_shift_req;
        state_n = state;
        cnt_n = cnt;
        step = 1'b0;
        if (pkt_active) state_n = FROZEN;
        else if (state != STEP_WAIT || req_c == cur_shift) begin
            state_n = req_c == cur_shift ? IDLE : STEP_WAIT;
            cnt_n = '0;
        end else if (s.in_valid) begin
            step = cnt == CW'(STEP_INTERVAL - 1);
            cnt_n = step ? '0 : cnt + CW'(1);
        end
        shift_n = !step ? cur_shift : req_c > cur_shift ? cur_shift + 3'd1 : cur_shift - 3'd1;
    end
    sat_shift #(.DW(DATA_WIDTH), .MS(MAX_SHIFT)) u_sat_i (.d(i1), .sh(s1), .y(i_y), .sat(i_sat));
    sat_shift #(.DW(DATA_WIDTH), .MS(MAX_SHIFT)) u_sat_q (.d(q1), .sh(s1), .y(q_y), .sat(q_sat));
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            cur_shift <= '0;
            shift_changed <= 1'b0;
            v1 <= 1'b0;
            i1 <= '0;
            q1 <= '0;
            s1 <= '0;
            s.out_valid <= 1'b0;
            s.sat_pulse <= 1'b0;
            s.i_out <= '0;
            s.q_out <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            cur_shift <= shift_n;
            shift_changed <= step;
            v1 <= s.in_valid;
            // the shift is captured with the sample so I and Q always share it
            if (s.in_valid) begin
                i1 <= s.i_in;
                q1 <= s.q_in;
                s1 <= cur_shift;
            end
            s.out_valid <= v1;
            s.sat_pulse <= v1 && (i_sat || q_sat);
            if (v1) begin
                s.i_out <= i_y;
                s.q_out <= q_y;
            end
        end
    end
endmodule

// File: tb/tb_gain_shift_apply.sv
// tb_gain_shift_apply: directed vector table plus hand sequences for stepping, freeze and reset.
module tb_gain_shift_apply;
    logic clk = 1'b0, reset = 1'b1, pkt_active = 1'b0, shift_changed;
    logic [2:0] num_shift_req = 3'd0, cur_shift;
    int checks = 0, failures = 0, pulses, maxs, n;

    gain_shift_apply_if #(.DATA_WIDTH(16)) bus();
    gain_shift_apply dut (.clk(clk), .reset(reset), .num_shift_req(num_shift_req), .pkt_active(pkt_active),
                          .s(bus.slave), .cur_shift(cur_shift), .shift_changed(shift_changed));

    always #5 clk = ~clk;

    typedef struct {logic [2:0] sh; int i, q, ei, eq; logic sat;} vec_t;
    vec_t v[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        pkt_active = 1'b0;
        num_shift_req = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic move_to(input logic [2:0] t);
        int k = 0;
        num_shift_req = t;
        bus.in_valid = 1'b1;
        bus.i_in = '0;
        bus.q_in = '0;
        while (cur_shift != t && k < 600) begin
            @(negedge clk);
            k++;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk($sformatf("move_to_%0d", t), int'(cur_shift), int'(t));
    endtask

    initial begin
        v[0] = '{3'd2, 100, -100, 400, -400, 1'b0};
        v[1] = '{3'd2, 8191, -8192, 32764, -32768, 1'b0};
        v[2] = '{3'd2, 8192, -8193, 32767, -32768, 1'b1};
        v[3] = '{3'd3, 1000, -5000, 8000, -32768, 1'b1};
        v[4] = '{3'd3, -4096, 4095, -32768, 32760, 1'b0};
        v[5] = '{3'd4, 2304, -2304, 32767, -32768, 1'b1};
        v[6] = '{3'd4, 2047, -2048, 32752, -32768, 1'b0};
        v[7] = '{3'd4, 0, -1, 0, -16, 1'b0};
        v[8] = '{3'd0, -32768, 32767, -32768, 32767, 1'b0};
        v[9] = '{3'd0, 5, -5, 5, -5, 1'b0};
        bus.in_valid = 1'b0;
        bus.i_in = '0;
        bus.q_in = '0;

        bus.i_in = 16'sd77;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_i_out", int'(bus.i_out), 0);
        chk("rst_q_out", int'(bus.q_out), 0);
        chk("rst_sat", int'(bus.sat_pulse), 0);
        chk("rst_cur_shift", int'(cur_shift), 0);
        chk("rst_shift_changed", int'(shift_changed), 0);
        do_reset();

        for (int k = 0; k < 10; k++) begin
            if (cur_shift != v[k].sh) move_to(v[k].sh);
            bus.in_valid = 1'b1;
            bus.i_in = 16'(v[k].i);
            bus.q_in = 16'(v[k].q);
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_early", k), int'(bus.out_valid), 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", k), int'(bus.out_valid), 1);
            chk($sformatf("vec%0d_i", k), int'(bus.i_out), v[k].ei);
            chk($sformatf("vec%0d_q", k), int'(bus.q_out), v[k].eq);
            chk($sformatf("vec%0d_sat", k), int'(bus.sat_pulse), int'(v[k].sat));
            @(negedge clk);
            chk($sformatf("vec%0d_idle_valid", k), int'(bus.out_valid), 0);
            chk($sformatf("vec%0d_hold_i", k), int'(bus.i_out), v[k].ei);
            chk($sformatf("vec%0d_idle_sat", k), int'(bus.sat_pulse), 0);
        end

        do_reset();
        num_shift_req = 3'd3;
        bus.in_valid = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (shift_changed) begin
                pulses++;
                chk("ramp_step_time", k, 65 + 64 * (pulses - 1));
                chk("ramp_step_value", int'(cur_shift), pulses);
            end
        end
        chk("ramp_pulses", pulses, 3);
        chk("ramp_final", int'(cur_shift), 3);

        do_reset();
        num_shift_req = 3'd1;
        bus.in_valid = 1'b1;
        repeat (64) @(negedge clk);
        pkt_active = 1'b1;
        @(negedge clk);
        chk("frz_no_pulse", int'(shift_changed), 0);
        chk("frz_no_step", int'(cur_shift), 0);
        repeat (10) @(negedge clk);
        chk("frz_held", int'(cur_shift), 0);
        pkt_active = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            pulses += int'(shift_changed);
        end
        chk("frz_early_pulses", pulses, 0);
        @(negedge clk);
        chk("frz_step_pulse", int'(shift_changed), 1);
        chk("frz_step_value", int'(cur_shift), 1);

        do_reset();
        num_shift_req = 3'd7;
        bus.in_valid = 1'b1;
        pulses = 0;
        maxs = 0;
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            pulses += int'(shift_changed);
            if (int'(cur_shift) > maxs) maxs = int'(cur_shift);
        end
        chk("clamp_max", maxs, 4);
        chk("clamp_pulses", pulses, 4);
        chk("clamp_final", int'(cur_shift), 4);

        do_reset();
        num_shift_req = 3'd2;
        bus.in_valid = 1'b1;
        repeat (85) @(negedge clk);
        chk("tog_up", int'(cur_shift), 1);
        num_shift_req = 3'd0;
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (shift_changed) begin
                pulses++;
                chk("tog_time", k, 44);
                chk("tog_value", int'(cur_shift), 0);
            end
        end
        chk("tog_pulses", pulses, 1);
        chk("tog_final", int'(cur_shift), 0);

        do_reset();
        bus.in_valid = 1'b1;
        bus.i_in = 16'sd100;
        bus.q_in = -16'sd50;
        @(negedge clk);
        bus.i_in = 16'sd200;
        reset = 1'b1;
        @(negedge clk);
        chk("flush_valid", int'(bus.out_valid), 0);
        chk("flush_i", int'(bus.i_out), 0);
        chk("flush_q", int'(bus.q_out), 0);
        chk("flush_sat", int'(bus.sat_pulse), 0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n += int'(bus.out_valid);
        end
        chk("flush_quiet", n, 0);
        bus.in_valid = 1'b1;
        bus.i_in = 16'sd123;
        bus.q_in = -16'sd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("post_rst_early", int'(bus.out_valid), 0);
        @(negedge clk);
        chk("post_rst_valid", int'(bus.out_valid), 1);
        chk("post_rst_i", int'(bus.i_out), 123);
        chk("post_rst_q", int'(bus.q_out), -7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
